// File: rtl/elf_image_loader_pkg.sv
// Shared types and constants for the ELF image loader.
// Imported by the top and the byte packer.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_TEXT,
    ST_DATA,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_TEXT_SIZE = 2'd1,
    ERR_BOUNDS    = 2'd2,
    ERR_ENTRY     = 2'd3
  } loader_err_t;

  localparam int TEXT_WORD_BYTES = 4;
  localparam int DATA_WORD_BYTES = 8;

endpackage

// File: rtl/elf_image_loader_byte_packer.sv
// Little-endian byte-to-word packer with zero-filled flush.
// The word completes in the same cycle its last byte arrives.
module byte_packer
  import loader_pkg::*;
#(
  parameter int WORD_BYTES = TEXT_WORD_BYTES,
  parameter int IDX_W      = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    clr_in,
  input  logic                    byte_valid_in,
  input  logic [7:0]              byte_in,
  input  logic                    flush_in,
  output logic                    word_valid_out,
  output logic [8*WORD_BYTES-1:0] word_data_out,
  output logic [IDX_W-1:0]        word_idx_out
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     byte_sh;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full;

  always_comb begin
    byte_sh        = W'(byte_in) << {cnt_q, 3'b000};
    full           = byte_valid_in && (cnt_q == CW'(WORD_BYTES - 1));
    word_valid_out = full || flush_in;
    word_data_out  = '0;
    if (word_valid_out) begin
      word_data_out = acc_q | (full ? byte_sh : '0);
    end
    cnt_d = cnt_q;
    acc_d = acc_q;
    idx_d = idx_q;
    if (clr_in) begin
      cnt_d = '0;
      acc_d = '0;
      idx_d = '0;
    end else if (word_valid_out) begin
      cnt_d = '0;
      acc_d = '0;
      idx_d = idx_q + 1'b1;
    end else if (byte_valid_in) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = acc_q | byte_sh;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

  assign word_idx_out = idx_q;

endmodule

// File: rtl/elf_image_loader.sv
// Boot loader: streams the ELF byte image into instruction and
// data memories, validates layout, then releases the core.
module elf_image_loader
  import loader_pkg::*;
#(
  parameter int ADDR_SIZE   = 4096,
  parameter int IMEM_WORDS  = 1024,
  parameter int DMEM_DWORDS = 512
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           init_in,
  input  logic [63:0]                    text_start_addr_in,
  input  logic [63:0]                    data_start_addr_in,
  input  logic [63:0]                    text_size_in,
  input  logic [63:0]                    data_size_in,
  input  logic [63:0]                    entry_in,
  output logic [$clog2(ADDR_SIZE)-1:0]   img_rd_addr_out,
  input  logic [7:0]                     img_rd_data_in,
  output logic                           imem_wr_en_out,
  output logic [$clog2(IMEM_WORDS)-1:0]  imem_wr_addr_out,
  output logic [31:0]                    imem_wr_data_out,
  output logic                           dmem_wr_en_out,
  output logic [$clog2(DMEM_DWORDS)-1:0] dmem_wr_addr_out,
  output logic [63:0]                    dmem_wr_data_out,
  output logic [63:0]                    pc_init_out,
  output logic                           core_start_out,
  output logic                           busy_out,
  output logic                           error_out,
  output logic [1:0]                     error_code_out
);

  localparam int AW = $clog2(ADDR_SIZE);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_DWORDS);

  loader_state_t state_q, state_d;
  loader_err_t   code_q, code_d, chk;

  logic [63:0]   t_q, t_d, d_q, d_d;
  logic [63:0]   ts_q, ts_d, entry_q, entry_d;
  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          vld_q, vld_d, sec_q, sec_d;
  logic          flush_q, flush_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d, err_q, err_d;

  logic [64:0]   td_sum, text_end;
  logic [63:0]   d_dwords;
  logic          accept, last_text, last_data, need_flush;

  logic          t_vld, d_vld;
  logic [31:0]   t_data;
  logic [63:0]   d_data;
  logic [IW-1:0] t_idx;
  logic [DW-1:0] d_idx;

  // Memory addresses are section offsets, so the data base is not needed.
  logic unused_data_start;
  assign unused_data_start = ^data_start_addr_in;

  assign accept = init_in &&
    (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

  always_comb begin
    td_sum   = {1'b0, t_q} + {1'b0, d_q};
    text_end = {1'b0, ts_q} + {1'b0, t_q};
    d_dwords = (d_q >> 3) + {63'd0, |d_q[2:0]};
    chk      = ERR_NONE;
    if (t_q == 64'd0 || t_q[1:0] != 2'd0 ||
        (t_q >> 2) > 64'(IMEM_WORDS)) begin
      chk = ERR_TEXT_SIZE;
    end else if (td_sum > 65'(ADDR_SIZE) ||
                 d_dwords > 64'(DMEM_DWORDS)) begin
      chk = ERR_BOUNDS;
    end else if (entry_q < ts_q ||
                 {1'b0, entry_q} >= text_end ||
                 entry_q[1:0] != 2'd0) begin
      chk = ERR_ENTRY;
    end
  end

  assign last_text  = 64'(rd_addr_q) == t_q - 64'd1;
  assign last_data  = 64'(rd_addr_q) == t_q + d_q - 64'd1;
  assign need_flush = |d_q[2:0];

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    t_d       = t_q;
    d_d       = d_q;
    ts_d      = ts_q;
    entry_d   = entry_q;
    pc_d      = pc_q;
    rd_addr_d = rd_addr_q;
    vld_d     = 1'b0;
    sec_d     = sec_q;
    flush_d   = 1'b0;
    start_d   = start_q;
    busy_d    = busy_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (init_in) begin
          t_d     = text_size_in;
          d_d     = data_size_in;
          ts_d    = text_start_addr_in;
          entry_d = entry_in;
          pc_d    = '0;
          start_d = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk != ERR_NONE) begin
          err_d   = 1'b1;
          code_d  = chk;
          busy_d  = 1'b0;
          state_d = ST_ERROR;
        end else begin
          rd_addr_d = '0;
          state_d   = ST_TEXT;
        end
      end
      ST_TEXT: begin
        vld_d     = 1'b1;
        sec_d     = 1'b0;
        rd_addr_d = rd_addr_q + 1'b1;
        if (last_text) begin
          state_d = (d_q == 64'd0) ? ST_DRAIN : ST_DATA;
        end
      end
      ST_DATA: begin
        vld_d     = 1'b1;
        sec_d     = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        if (last_data) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // First DRAIN cycle always carries the final byte.
        if (flush_q || (vld_q && !(sec_q && need_flush))) begin
          start_d = 1'b1;
          pc_d    = entry_q;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (vld_q) begin
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      code_q    <= ERR_NONE;
      t_q       <= '0;
      d_q       <= '0;
      ts_q      <= '0;
      entry_q   <= '0;
      pc_q      <= '0;
      rd_addr_q <= '0;
      vld_q     <= 1'b0;
      sec_q     <= 1'b0;
      flush_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      t_q       <= t_d;
      d_q       <= d_d;
      ts_q      <= ts_d;
      entry_q   <= entry_d;
      pc_q      <= pc_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      sec_q     <= sec_d;
      flush_q   <= flush_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  byte_packer #(
    .WORD_BYTES(TEXT_WORD_BYTES),
    .IDX_W     (IW)
  ) u_text_packer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clr_in        (accept),
    .byte_valid_in (vld_q & ~sec_q),
    .byte_in       (img_rd_data_in),
    .flush_in      (1'b0),
    .word_valid_out(t_vld),
    .word_data_out (t_data),
    .word_idx_out  (t_idx)
  );

  byte_packer #(
    .WORD_BYTES(DATA_WORD_BYTES),
    .IDX_W     (DW)
  ) u_data_packer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clr_in        (accept),
    .byte_valid_in (vld_q & sec_q),
    .byte_in       (img_rd_data_in),
    .flush_in      (flush_q),
    .word_valid_out(d_vld),
    .word_data_out (d_data),
    .word_idx_out  (d_idx)
  );

  assign img_rd_addr_out  = rd_addr_q;
  assign imem_wr_en_out   = t_vld;
  assign imem_wr_addr_out = t_vld ? t_idx : '0;
  assign imem_wr_data_out = t_data;
  assign dmem_wr_en_out   = d_vld;
  assign dmem_wr_addr_out = d_vld ? d_idx : '0;
  assign dmem_wr_data_out = d_data;
  assign pc_init_out      = pc_q;
  assign core_start_out   = start_q;
  assign busy_out         = busy_q;
  assign error_out        = err_q;
  assign error_code_out   = code_q;

endmodule
